ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same open-drain clock/data pair that the keyboard controller receives on. It implements the full host-side sequence:
- clock inhibit;
- request-to-send;
- bit shifting on device clock edges;
- odd parity and stop bit;
- ACK check and timeout.

It sits beside the keyboard controller in the top level. The top-level wrapper turns its drive-low outputs into open-drain pins.

---
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// a byte with odd parity on device clock falls, check ACK, time out.
module ps2_line_filter #(
  parameter int LEN = 8
) (
  input  logic clk_vga,
  input  logic reset_btn,
  input  logic i_pin,
  output logic o_level
);
  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] CMAX = FW'(LEN - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [FW-1:0] r_cnt;

  // level is accepted only after LEN consecutive differing samples
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IMAX = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_clk;
  logic          w_dat;
  logic          r_cprev;
  logic          w_fall;
  logic          w_tmo;
  logic          w_set_done;
  logic          w_set_err;
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_bits;
  logic [8:0]    r_shift;
  logic          r_dlow;
  logic          r_done;
  logic          r_err;

  ps2_line_filter #(.LEN(FILTER_LEN)) u_fclk (
    .clk_vga  (clk_vga),
    .reset_btn(reset_btn),
    .i_pin    (ps2_clock_in),
    .o_level  (w_clk)
  );

  ps2_line_filter #(.LEN(FILTER_LEN)) u_fdat (
    .clk_vga  (clk_vga),
    .reset_btn(reset_btn),
    .i_pin    (ps2_data_in),
    .o_level  (w_dat)
  );

  assign w_fall = r_cprev & ~w_clk;
  // a fall event restarts the timer, so it never times out on that cycle
  assign w_tmo  = (r_tcnt == TMAX) & ~w_fall;

  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_set_err  = 1'b0;
    unique case (r_state)
      S_IDLE:    if (tx_valid) w_next = S_INHIBIT;
      S_INHIBIT: if (r_icnt == IMAX) w_next = S_REQ;
      S_REQ:     w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_fall && r_bits == 4'd9) begin
          w_next = S_ACK;
        end else if (w_tmo) begin
          w_next    = S_FIN;
          w_set_err = 1'b1;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_next    = w_dat ? S_FIN : S_WAIT;
          w_set_err = w_dat;
        end else if (w_tmo) begin
          w_next    = S_FIN;
          w_set_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_clk && w_dat) begin
          w_next     = S_FIN;
          w_set_done = 1'b1;
        end else if (w_tmo) begin
          w_next    = S_FIN;
          w_set_err = 1'b1;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      r_cprev <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_icnt  <= '0;
      r_tcnt  <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_dlow  <= 1'b0;
    end else begin
      r_cprev <= w_clk;
      r_done  <= w_set_done;
      r_err   <= w_set_err;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shift <= {~^tx_data, tx_data};
            r_icnt  <= '0;
          end
        end
        S_INHIBIT: r_icnt <= r_icnt + 1'b1;
        S_REQ: begin
          r_bits <= '0;
          r_tcnt <= '0;
          r_dlow <= 1'b1;
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_tcnt <= '0;
            r_bits <= r_bits + 1'b1;
            // events 1-9 present data then parity; event 10 is the stop bit
            if (r_bits < 4'd9) begin
              r_dlow  <= ~r_shift[0];
              r_shift <= {1'b0, r_shift[8:1]};
            end else begin
              r_dlow <= 1'b0;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_ACK, S_WAIT: begin
          if (w_fall) r_tcnt <= '0;
          else        r_tcnt <= r_tcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_ready            = (r_state == S_IDLE);
  assign busy                = ~tx_ready;
  assign ps2_clock_drive_low = (r_state == S_INHIBIT);
  assign ps2_data_drive_low  = (r_state == S_REQ) |
                               ((r_state == S_SHIFT) & r_dlow);
  assign done                = r_done;
  assign error               = r_err;
endmodule
